// File: rtl/dct_mac_unit.sv
// 8-tap signed multiply-accumulate stage for the 1-D DCT: multiply, accumulate,
// then round half toward +inf, shift and saturate one term per 8-tap run.
module dct_mac_unit #(
  parameter int DW    = 8,
  parameter int CW    = 12,
  parameter int ACCW  = 23,
  parameter int OW    = 11,
  parameter int SHIFT = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic          in_valid_i,
  input  logic          in_first_i,
  input  logic [DW-1:0] in_data_i,
  input  logic [CW-1:0] in_coef_i,
  output logic [OW-1:0] result_o,
  output logic          result_valid_o,
  output logic          err_seq_o
);

  localparam int PW = DW + CW;

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic signed [ACCW:0] HALF    = (ACCW+1)'(1) << (SHIFT-1);
  localparam logic signed [ACCW:0] SAT_MAX = {{(ACCW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_MIN = {{(ACCW+2-OW){1'b1}}, {(OW-1){1'b0}}};

  state_e                 state_q;
  logic [2:0]             cnt_q;
  logic                   err_q;
  logic                   v1_q, first1_q, last1_q;
  logic signed [PW-1:0]   p1_q;
  logic                   last2_q;
  logic signed [ACCW-1:0] acc_q;
  logic [OW-1:0]          result_q;
  logic                   result_valid_q;

  logic signed [PW-1:0]   data_ext, coef_ext, prod;
  logic signed [ACCW-1:0] p_ext;
  logic signed [ACCW:0]   acc_sx, rnd, shifted;
  logic [OW-1:0]          sat_r;

  always_comb begin
    data_ext = {{CW{in_data_i[DW-1]}}, in_data_i};
    coef_ext = {{DW{in_coef_i[CW-1]}}, in_coef_i};
    prod     = data_ext * coef_ext;
    p_ext    = {{(ACCW-PW){p1_q[PW-1]}}, p1_q};
    // one guard bit so the rounding add cannot wrap
    acc_sx   = {acc_q[ACCW-1], acc_q};
    rnd      = acc_sx + HALF;
    shifted  = rnd >>> SHIFT;
    if (shifted > SAT_MAX)      sat_r = SAT_MAX[OW-1:0];
    else if (shifted < SAT_MIN) sat_r = SAT_MIN[OW-1:0];
    else                        sat_r = shifted[OW-1:0];
  end

  // Sequencer and S1: tags each accepted sample as first/last and registers its product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      p1_q     <= '0;
    end else if (enable_i) begin
      err_q    <= 1'b0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      p1_q     <= prod;
      if (in_valid_i) begin
        case (state_q)
          IDLE: begin
            if (in_first_i) begin
              state_q  <= RUN;
              cnt_q    <= 3'd1;
              v1_q     <= 1'b1;
              first1_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          RUN: begin
            v1_q <= 1'b1;
            if (in_first_i) begin
              err_q    <= 1'b1;
              cnt_q    <= 3'd1;
              first1_q <= 1'b1;
            end else if (cnt_q == 3'd7) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              last1_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // S2 accumulate, S3 round/saturate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last2_q        <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if (enable_i) begin
      last2_q <= v1_q & last1_q;
      if (v1_q) acc_q <= first1_q ? p_ext : acc_q + p_ext;
      result_valid_q <= last2_q;
      if (last2_q) result_q <= sat_r;
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign err_seq_o      = err_q;

endmodule

// File: tb/tb_dct_mac_unit.sv
// Directed and randomized checks of dct_mac_unit against a tap-list reference model.
module tb_dct_mac_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i, in_valid_i, in_first_i;
  logic [7:0]  in_data_i;
  logic [11:0] in_coef_i;
  logic [10:0] result_o;
  logic        result_valid_o, err_seq_o;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit     m_run;
  int     m_cnt;
  longint m_sum;
  int     pend_val[$];
  int     pend_cnt[$];
  int     exp_res, exp_valid, exp_err;

  dct_mac_unit dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .in_valid_i(in_valid_i),
    .in_first_i(in_first_i), .in_data_i(in_data_i), .in_coef_i(in_coef_i),
    .result_o(result_o), .result_valid_o(result_valid_o), .err_seq_o(err_seq_o)
  );

  always #5 clk = ~clk;

  function automatic int dct_term(longint s);
    longint r;
    r = (s + 512) >>> 10;
    if (r > 1023) r = 1023;
    if (r < -1024) r = -1024;
    return int'(r);
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".result"}, {{21{result_o[10]}}, result_o}, exp_res);
    chk({tag, ".valid"}, {31'd0, result_valid_o}, exp_valid);
    chk({tag, ".err"}, {31'd0, err_seq_o}, exp_err);
  endtask

  task automatic model_clear();
    m_run = 0; m_cnt = 0; m_sum = 0;
    pend_val.delete(); pend_cnt.delete();
    exp_res = 0; exp_valid = 0; exp_err = 0;
  endtask

  task automatic step(string tag, bit en, bit v, bit f, int d, int c);
    enable_i = en; in_valid_i = v; in_first_i = f;
    in_data_i = d[7:0]; in_coef_i = c[11:0];
    if (en) begin
      exp_valid = 0; exp_err = 0;
      foreach (pend_cnt[i]) pend_cnt[i]--;
      if (pend_cnt.size() > 0 && pend_cnt[0] == 0) begin
        exp_valid = 1; exp_res = pend_val[0];
        void'(pend_val.pop_front()); void'(pend_cnt.pop_front());
      end
      if (v) begin
        if (f) begin
          if (m_run) exp_err = 1;
          m_run = 1; m_cnt = 1; m_sum = longint'(d) * longint'(c);
        end else if (!m_run) begin
          exp_err = 1;
        end else begin
          m_sum += longint'(d) * longint'(c);
          m_cnt++;
          if (m_cnt == 8) begin
            pend_val.push_back(dct_term(m_sum));
            pend_cnt.push_back(2);
            m_run = 0; m_cnt = 0;
          end
        end
      end
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic run8(string tag, int d, int c);
    for (int i = 0; i < 8; i++) step(tag, 1, 1, i == 0, d, c);
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable_i = 0; in_valid_i = 0; in_first_i = 0;
    in_data_i = '0; in_coef_i = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all("por");
    @(negedge clk) rst_n = 1'b1;

    run8("unit", 1, 1024);
    idle("unit_lat", 3);
    run8("possat", 127, 2047);
    run8("negsat", -128, 2047);
    idle("sat_flush", 3);
    run8("rnd_pos", 1, 64);
    run8("rnd_neg", -1, 64);
    idle("rnd_flush", 3);

    step("no_first", 1, 1, 0, 5, 7);
    idle("no_first_idle", 3);
    for (int i = 0; i < 4; i++) step("abort_pre", 1, 1, i == 0, 3, 100);
    run8("abort_run", 2, 300);
    idle("abort_flush", 3);
    // abort right after a last tap: the previous result must still land
    run8("abort_prev", 10, 200);
    for (int i = 0; i < 3; i++) step("abort_next", 1, 1, i == 0, 7, 9);
    step("abort_hit", 1, 1, 1, 4, 4);
    idle("abort_hit_flush", 4);

    for (int i = 0; i < 4; i++) step("stall_a", 1, 1, i == 0, 20, -500);
    for (int i = 0; i < 3; i++) step("stall_frz", 0, 1, 1, 99, 99);
    for (int i = 4; i < 8; i++) step("stall_b", 1, 1, 0, 20, -500);
    step("stall_pulse", 1, 0, 0, 0, 0);
    step("stall_hold", 0, 0, 0, 0, 0);
    step("stall_hold2", 0, 0, 0, 0, 0);
    idle("stall_flush", 3);

    for (int i = 0; i < 5; i++) step("rst_pre", 1, 1, i == 0, 50, 1000);
    do_reset();
    for (int i = 5; i < 8; i++) step("rst_post", 1, 1, 0, 50, 1000);
    idle("rst_flush", 4);

    for (int n = 0; n < 800; n++) begin
      bit en, v, f;
      int d, c;
      en = $urandom_range(0, 9) != 0;
      v  = $urandom_range(0, 3) != 0;
      if (m_cnt == 0) f = $urandom_range(0, 15) != 0;
      else            f = $urandom_range(0, 24) == 0;
      d = int'($urandom_range(0, 255)) - 128;
      c = int'($urandom_range(0, 4095)) - 2048;
      step("rand", en, v, f, d, c);
    end
    idle("rand_flush", 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
